// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control FSM: sequences IF/ID/EXE/MEM/WB phases.
// Decoded class is captured in ID and held until the instruction retires.
module multicycle_control_unit #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int ENABLE_JAL_JR = 1,
  parameter int CNT_W         = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             sign,
  input  logic             mem_ready,
  output logic             PCWre,
  output logic             IRWre,
  output logic             RegWre,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             DBDataSrc,
  output logic             ExtSel,
  output logic             InsMemRW,
  output logic             RD,
  output logic             WR,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUOp,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_AL = 4'b0010,
    S_WB_AL  = 4'b0011,
    S_EXE_BR = 4'b0100,
    S_EXE_LS = 4'b0101,
    S_MEM    = 4'b0110,
    S_WB_LD  = 4'b0111,
    S_HALT   = 4'b1000
  } state_t;

  typedef enum logic [4:0] {
    C_ILL, C_ADD, C_SUB, C_AND, C_OR, C_SLL, C_JR,
    C_ADDIU, C_ANDI, C_ORI, C_SLTI, C_SW, C_LW,
    C_BEQ, C_BNE, C_BLEZ, C_J, C_JAL, C_HALT
  } cls_t;

  state_t           r_state;
  state_t           w_next;
  cls_t             r_cls;
  cls_t             w_dec;
  cls_t             w_cls;
  logic             w_rdy;
  logic             w_rtype;
  logic             w_take;
  logic [CNT_W-1:0] r_retired;

  assign w_rdy   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state   = r_state;
  assign retired = r_retired;

  always_comb begin
    w_dec = C_ILL;
    unique case (OpCode)
      6'b000000: begin
        unique case (func)
          6'b100000: w_dec = C_ADD;
          6'b100010: w_dec = C_SUB;
          6'b100100: w_dec = C_AND;
          6'b100101: w_dec = C_OR;
          6'b000000: w_dec = C_SLL;
          6'b001000: w_dec = C_JR;
          default:   w_dec = C_ILL;
        endcase
      end
      6'b001001: w_dec = C_ADDIU;
      6'b001100: w_dec = C_ANDI;
      6'b001101: w_dec = C_ORI;
      6'b001010: w_dec = C_SLTI;
      6'b101011: w_dec = C_SW;
      6'b100011: w_dec = C_LW;
      6'b000100: w_dec = C_BEQ;
      6'b000101: w_dec = C_BNE;
      6'b000110: w_dec = C_BLEZ;
      6'b000010: w_dec = C_J;
      6'b000011: w_dec = C_JAL;
      6'b111111: w_dec = C_HALT;
      default:   w_dec = C_ILL;
    endcase
    if ((ENABLE_JAL_JR == 0) &&
        ((w_dec == C_JAL) || (w_dec == C_JR)))
      w_dec = C_ILL;
  end

  // Live decode in ID, latched class afterwards, neutral elsewhere
  always_comb begin
    w_cls = C_ILL;
    unique case (r_state)
      S_ID:    w_cls = w_dec;
      S_EXE_AL, S_WB_AL, S_EXE_BR,
      S_EXE_LS, S_MEM, S_WB_LD:
               w_cls = r_cls;
      default: w_cls = C_ILL;
    endcase
  end

  assign w_rtype = (w_cls == C_ADD) || (w_cls == C_SUB) ||
                   (w_cls == C_AND) || (w_cls == C_OR)  ||
                   (w_cls == C_SLL);

  always_comb begin
    ALUOp   = 3'b000;
    ALUSrcA = 1'b0;
    ALUSrcB = 1'b0;
    ExtSel  = 1'b1;
    unique case (w_cls)
      C_SUB, C_BEQ, C_BNE, C_BLEZ:
        ALUOp = 3'b001;
      C_SLL: begin
        ALUOp   = 3'b010;
        ALUSrcA = 1'b1;
      end
      C_OR:  ALUOp = 3'b011;
      C_AND: ALUOp = 3'b100;
      C_ORI: begin
        ALUOp   = 3'b011;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b0;
      end
      C_ANDI: begin
        ALUOp   = 3'b100;
        ALUSrcB = 1'b1;
        ExtSel  = 1'b0;
      end
      C_SLTI: begin
        ALUOp   = 3'b110;
        ALUSrcB = 1'b1;
      end
      C_ADDIU, C_LW, C_SW:
        ALUSrcB = 1'b1;
      default: ALUOp = 3'b000;
    endcase
  end

  always_comb begin
    w_take = 1'b0;
    unique case (1'b1)
      (w_cls == C_BEQ):  w_take = zero;
      (w_cls == C_BNE):  w_take = ~zero;
      (w_cls == C_BLEZ): w_take = zero | sign;
      default:           w_take = 1'b0;
    endcase
  end

  always_comb begin
    w_next    = S_IF;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    DBDataSrc = 1'b0;
    InsMemRW  = 1'b0;
    RD        = 1'b1;
    WR        = 1'b1;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    PCSrc     = 2'b00;
    illegal   = 1'b0;
    unique case (r_state)
      S_IF: begin
        InsMemRW = 1'b1;
        IRWre    = w_rdy;
        w_next   = w_rdy ? S_ID : S_IF;
      end
      S_ID: begin
        unique case (w_dec)
          C_J: begin
            PCWre = 1'b1;
            PCSrc = 2'b11;
          end
          C_JAL: begin
            PCWre  = 1'b1;
            PCSrc  = 2'b11;
            RegWre = 1'b1;
          end
          C_JR: begin
            PCWre = 1'b1;
            PCSrc = 2'b10;
          end
          C_HALT: w_next = S_HALT;
          C_ILL: begin
            illegal = 1'b1;
            PCWre   = 1'b1;
          end
          C_BEQ, C_BNE, C_BLEZ:
            w_next = S_EXE_BR;
          C_LW, C_SW:
            w_next = S_EXE_LS;
          default: w_next = S_EXE_AL;
        endcase
      end
      S_EXE_AL: w_next = S_WB_AL;
      S_WB_AL: begin
        RegWre    = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst    = w_rtype ? 2'b10 : 2'b01;
        PCWre     = 1'b1;
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        PCSrc = w_take ? 2'b01 : 2'b00;
      end
      S_EXE_LS: w_next = S_MEM;
      S_MEM: begin
        if (w_cls == C_SW) begin
          WR     = 1'b0;
          PCWre  = w_rdy;
          w_next = w_rdy ? S_IF : S_MEM;
        end else begin
          RD     = 1'b0;
          w_next = w_rdy ? S_WB_LD : S_MEM;
        end
      end
      S_WB_LD: begin
        RegWre    = 1'b1;
        RegDst    = 2'b01;
        DBDataSrc = 1'b1;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state   <= S_IF;
      r_cls     <= C_ILL;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID)
        r_cls <= w_dec;
      if (PCWre)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected traces
// built from the instruction-class rules, random handshake and flags.
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] OpCode;
  logic [5:0] func;
  logic       zero;
  logic       sign;
  logic       mem_ready;

  logic PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB;
  logic DBDataSrc, ExtSel, InsMemRW, RD, WR, WrRegDSrc, illegal;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic [31:0] retired;

  logic n_PCWre, n_IRWre, n_RegWre, n_ALUSrcA, n_ALUSrcB;
  logic n_DBDataSrc, n_ExtSel, n_InsMemRW, n_RD, n_WR;
  logic n_WrRegDSrc, n_illegal;
  logic [1:0] n_RegDst, n_PCSrc;
  logic [2:0] n_ALUOp;
  logic [3:0] n_state;
  logic [2:0] n_retired;

  always #5 CLK = ~CLK;

  multicycle_control_unit u_dut (
    .CLK(CLK), .Reset(Reset), .OpCode(OpCode), .func(func),
    .zero(zero), .sign(sign), .mem_ready(mem_ready),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc),
    .ExtSel(ExtSel), .InsMemRW(InsMemRW), .RD(RD), .WR(WR),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .PCSrc(PCSrc),
    .ALUOp(ALUOp), .state(state), .illegal(illegal),
    .retired(retired)
  );

  multicycle_control_unit #(
    .MEM_HANDSHAKE(1), .ENABLE_JAL_JR(0), .CNT_W(3)
  ) u_nojj (
    .CLK(CLK), .Reset(Reset), .OpCode(OpCode), .func(func),
    .zero(zero), .sign(sign), .mem_ready(mem_ready),
    .PCWre(n_PCWre), .IRWre(n_IRWre), .RegWre(n_RegWre),
    .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB),
    .DBDataSrc(n_DBDataSrc), .ExtSel(n_ExtSel),
    .InsMemRW(n_InsMemRW), .RD(n_RD), .WR(n_WR),
    .RegDst(n_RegDst), .WrRegDSrc(n_WrRegDSrc), .PCSrc(n_PCSrc),
    .ALUOp(n_ALUOp), .state(n_state), .illegal(n_illegal),
    .retired(n_retired)
  );

  typedef struct packed {
    logic [3:0] st;
    logic pcw; logic irw; logic rw; logic asa; logic asb;
    logic dbs; logic ext; logic imr; logic rd; logic wr;
    logic [1:0] dst; logic wrs; logic [1:0] psrc;
    logic [2:0] aop; logic ill;
  } vec_t;

  typedef enum {
    K_R, K_IMM, K_BR, K_LW, K_SW, K_J, K_JAL, K_JR, K_HALT, K_ILL
  } kind_t;

  typedef struct {
    kind_t k; logic [2:0] aop; bit asa; bit asb; bit ext; int br;
  } info_t;

  typedef struct { bit rdy; bit z; bit s; } stim_t;

  vec_t  w_obs, w_obs2;
  assign w_obs = {state, PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB,
                  DBDataSrc, ExtSel, InsMemRW, RD, WR, RegDst,
                  WrRegDSrc, PCSrc, ALUOp, illegal};
  assign w_obs2 = {n_state, n_PCWre, n_IRWre, n_RegWre, n_ALUSrcA,
                   n_ALUSrcB, n_DBDataSrc, n_ExtSel, n_InsMemRW,
                   n_RD, n_WR, n_RegDst, n_WrRegDSrc, n_PCSrc,
                   n_ALUOp, n_illegal};

  vec_t  exp_q[$];
  vec_t  msk_q[$];
  stim_t stm_q[$];
  int    id_pos;
  int    n_checks = 0;
  int    n_fail = 0;
  logic [31:0] m_ret = '0;
  logic [2:0]  m_ret2 = '0;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic info_t classify(logic [5:0] op, logic [5:0] fn);
    info_t d;
    d.k = K_ILL; d.aop = 3'b000; d.asa = 0; d.asb = 0;
    d.ext = 1; d.br = 0;
    case (op)
      6'b000000:
        case (fn)
          6'b100000: d.k = K_R;
          6'b100010: begin d.k = K_R; d.aop = 3'b001; end
          6'b100100: begin d.k = K_R; d.aop = 3'b100; end
          6'b100101: begin d.k = K_R; d.aop = 3'b011; end
          6'b000000: begin d.k = K_R; d.aop = 3'b010; d.asa = 1; end
          6'b001000: d.k = K_JR;
          default:   d.k = K_ILL;
        endcase
      6'b001001: begin d.k = K_IMM; d.asb = 1; end
      6'b001100: begin
        d.k = K_IMM; d.aop = 3'b100; d.asb = 1; d.ext = 0;
      end
      6'b001101: begin
        d.k = K_IMM; d.aop = 3'b011; d.asb = 1; d.ext = 0;
      end
      6'b001010: begin d.k = K_IMM; d.aop = 3'b110; d.asb = 1; end
      6'b101011: begin d.k = K_SW; d.asb = 1; end
      6'b100011: begin d.k = K_LW; d.asb = 1; end
      6'b000100: begin d.k = K_BR; d.aop = 3'b001; d.br = 0; end
      6'b000101: begin d.k = K_BR; d.aop = 3'b001; d.br = 1; end
      6'b000110: begin d.k = K_BR; d.aop = 3'b001; d.br = 2; end
      6'b000010: d.k = K_J;
      6'b000011: d.k = K_JAL;
      6'b111111: d.k = K_HALT;
      default:   d.k = K_ILL;
    endcase
    return d;
  endfunction

  function automatic vec_t base(logic [3:0] st);
    vec_t v = '0;
    v.st = st; v.rd = 1; v.wr = 1;
    return v;
  endfunction

  function automatic vec_t bmask();
    vec_t v = '0;
    v.st = '1; v.pcw = 1; v.irw = 1; v.rw = 1;
    v.rd = 1; v.wr = 1; v.ill = 1;
    return v;
  endfunction

  function automatic void push(vec_t e, vec_t m, bit r, bit z, bit s);
    stim_t t;
    t.rdy = r; t.z = z; t.s = s;
    exp_q.push_back(e); msk_q.push_back(m); stm_q.push_back(t);
  endfunction

  // Expected cycle-by-cycle trace of one instruction from fetch to retire
  function automatic void build(logic [5:0] op, logic [5:0] fn,
                                bit z, bit s, int wif, int wmem);
    info_t d = classify(op, fn);
    vec_t e, m;
    bit take;
    exp_q.delete(); msk_q.delete(); stm_q.delete();
    for (int i = 0; i < wif; i++) begin
      e = base(4'd0); e.imr = 1;
      m = bmask(); m.imr = 1;
      push(e, m, 0, rb(), rb());
    end
    e = base(4'd0); e.imr = 1; e.irw = 1;
    m = bmask(); m.imr = 1;
    push(e, m, 1, rb(), rb());
    id_pos = exp_q.size();
    e = base(4'd1);
    m = bmask();
    if (d.k inside {K_R, K_IMM, K_BR, K_LW, K_SW}) begin
      e.aop = d.aop; e.asa = d.asa; e.asb = d.asb; e.ext = d.ext;
      m.aop = '1; m.asa = 1; m.asb = 1; m.ext = 1;
    end
    case (d.k)
      K_J, K_JAL, K_JR: begin
        e.pcw = 1; m.psrc = '1;
        e.psrc = (d.k == K_JR) ? 2'b10 : 2'b11;
        if (d.k == K_JAL) begin
          e.rw = 1; e.dst = 2'b00; e.wrs = 0;
          m.dst = '1; m.wrs = 1;
        end
        push(e, m, rb(), rb(), rb());
      end
      K_ILL: begin
        e.ill = 1; e.pcw = 1; e.psrc = 2'b00; m.psrc = '1;
        push(e, m, rb(), rb(), rb());
      end
      K_HALT: push(e, m, rb(), rb(), rb());
      K_R, K_IMM: begin
        push(e, m, rb(), rb(), rb());
        e.st = 4'd2;
        push(e, m, rb(), rb(), rb());
        e.st = 4'd3; e.rw = 1; e.wrs = 1; e.dbs = 0; e.pcw = 1;
        e.dst = (d.k == K_R) ? 2'b10 : 2'b01; e.psrc = 2'b00;
        m.dst = '1; m.wrs = 1; m.dbs = 1; m.psrc = '1;
        push(e, m, rb(), rb(), rb());
      end
      K_BR: begin
        push(e, m, rb(), rb(), rb());
        take = (d.br == 0 && z) || (d.br == 1 && !z) ||
               (d.br == 2 && (z || s));
        e.st = 4'd4; e.pcw = 1; m.psrc = '1;
        e.psrc = take ? 2'b01 : 2'b00;
        push(e, m, rb(), z, s);
      end
      default: begin
        push(e, m, rb(), rb(), rb());
        e.st = 4'd5;
        push(e, m, rb(), rb(), rb());
        e.st = 4'd6;
        if (d.k == K_LW) e.rd = 0;
        else e.wr = 0;
        for (int i = 0; i < wmem; i++)
          push(e, m, 0, rb(), rb());
        if (d.k == K_SW) begin
          e.pcw = 1; e.psrc = 2'b00; m.psrc = '1;
          push(e, m, 1, rb(), rb());
        end else begin
          push(e, m, 1, rb(), rb());
          e.st = 4'd7; e.rd = 1; e.rw = 1; e.dst = 2'b01;
          e.dbs = 1; e.wrs = 1; e.pcw = 1; e.psrc = 2'b00;
          m.dst = '1; m.dbs = 1; m.wrs = 1; m.psrc = '1;
          push(e, m, rb(), rb(), rb());
        end
      end
    endcase
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input bit z, input bit s,
                           input int wif, input int wmem);
    info_t d = classify(op, fn);
    vec_t  e2;
    build(op, fn, z, s, wif, wmem);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK);
      if (i == 0) begin OpCode = op; func = fn; end
      mem_ready = stm_q[i].rdy;
      zero = stm_q[i].z;
      sign = stm_q[i].s;
      #1;
      n_checks++;
      if ((w_obs & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        n_fail++;
        $display("FAIL trace op=%b fn=%b step=%0d got=%h want=%h mask=%h",
                 op, fn, i, w_obs, exp_q[i], msk_q[i]);
      end
      e2 = exp_q[i];
      if (i == id_pos && d.k inside {K_JAL, K_JR}) begin
        e2.ill = 1; e2.psrc = 2'b00; e2.rw = 0;
      end
      n_checks++;
      if ((w_obs2 & msk_q[i]) !== (e2 & msk_q[i])) begin
        n_fail++;
        $display("FAIL nojj_trace op=%b fn=%b step=%0d got=%h want=%h",
                 op, fn, i, w_obs2, e2);
      end
    end
    if (d.k != K_HALT) begin
      m_ret  = m_ret + 32'd1;
      m_ret2 = m_ret2 + 3'd1;
    end
    @(posedge CLK); #1;
    n_checks++;
    if (retired !== m_ret || n_retired !== m_ret2) begin
      n_fail++;
      $display("FAIL retired op=%b got=%0d/%0d want=%0d/%0d",
               op, retired, n_retired, m_ret, m_ret2);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; mem_ready = 1'b0; zero = rb(); sign = rb();
    OpCode = 6'($urandom); func = 6'($urandom);
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if ({state, PCWre, IRWre, RegWre, RD, WR, PCSrc, ALUOp, illegal}
        !== {4'd0, 3'b000, 2'b11, 2'b00, 3'b000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs st=%b pcw=%b irw=%b rw=%b rd=%b wr=%b psrc=%b aop=%b ill=%b",
               state, PCWre, IRWre, RegWre, RD, WR, PCSrc, ALUOp, illegal);
    end
    n_checks++;
    if (retired !== 32'd0 || n_retired !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_retired got=%0d/%0d want=0", retired, n_retired);
    end
    m_ret = '0; m_ret2 = '0;
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  task automatic test_alu();
    run_instr(6'b000000, 6'b100000, 0, 0, 0, 0);
    run_instr(6'b000000, 6'b000000, 1, 0, 1, 0);
    run_instr(6'b001101, 6'($urandom), 0, 1, 0, 0);
    run_instr(6'b001010, 6'($urandom), 0, 0, 2, 0);
  endtask

  task automatic test_branch();
    run_instr(6'b000100, 6'($urandom), 1, 0, 0, 0);
    run_instr(6'b000101, 6'($urandom), 1, 0, 0, 0);
    run_instr(6'b000110, 6'($urandom), 0, 1, 0, 0);
    run_instr(6'b000110, 6'($urandom), 0, 0, 0, 0);
  endtask

  task automatic test_mem();
    run_instr(6'b100011, 6'($urandom), 0, 0, 0, 2);
    run_instr(6'b101011, 6'($urandom), 0, 0, 1, 1);
    run_instr(6'b101011, 6'($urandom), 0, 0, 0, 0);
  endtask

  task automatic test_jump();
    run_instr(6'b000011, 6'($urandom), 0, 0, 0, 0);
    run_instr(6'b000000, 6'b001000, 0, 0, 0, 0);
    run_instr(6'b000010, 6'($urandom), 0, 0, 1, 0);
  endtask

  task automatic test_illegal();
    run_instr(6'b111110, 6'($urandom), 0, 0, 0, 0);
    run_instr(6'b000000, 6'b111111, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [11:0] tbl [0:20] = '{
      {6'b000000, 6'b100000}, {6'b000000, 6'b100010},
      {6'b000000, 6'b100100}, {6'b000000, 6'b100101},
      {6'b000000, 6'b000000}, {6'b000000, 6'b001000},
      {6'b001001, 6'b000000}, {6'b001100, 6'b000000},
      {6'b001101, 6'b000000}, {6'b001010, 6'b000000},
      {6'b101011, 6'b000000}, {6'b100011, 6'b000000},
      {6'b000100, 6'b000000}, {6'b000101, 6'b000000},
      {6'b000110, 6'b000000}, {6'b000010, 6'b000000},
      {6'b000011, 6'b000000}, {6'b111110, 6'b000000},
      {6'b010000, 6'b000000}, {6'b000000, 6'b111111},
      {6'b000000, 6'b000011}
    };
    logic [11:0] ent;
    logic [5:0]  op, fn;
    for (int n = 0; n < 60; n++) begin
      ent = tbl[$urandom_range(0, 20)];
      op = ent[11:6];
      fn = (op == 6'b000000) ? ent[5:0] : 6'($urandom);
      run_instr(op, fn, rb(), rb(),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_mem();
    @(negedge CLK);
    OpCode = 6'b100011; func = 6'($urandom); mem_ready = 1'b1;
    @(negedge CLK);
    mem_ready = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if (state !== 4'd6 || RD !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_mem_setup st=%b rd=%b want st=0110 rd=0",
               state, RD);
    end
    Reset = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b1;
    n_checks++;
    if (state !== 4'd0 || retired !== 32'd0 || RD !== 1'b1 ||
        n_retired !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_mem_reset st=%b ret=%0d rd=%b want st=0 ret=0 rd=1",
               state, retired, RD);
    end
    m_ret = '0; m_ret2 = '0;
  endtask

  task automatic test_halt();
    int bad = 0;
    run_instr(6'b111111, 6'($urandom), 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      mem_ready = rb(); zero = rb(); sign = rb();
      OpCode = 6'($urandom); func = 6'($urandom);
      #1;
      if ({state, PCWre, RegWre, IRWre, RD, WR} !==
          {4'b1000, 3'b000, 2'b11})
        bad++;
    end
    n_checks++;
    if (bad != 0 || retired !== m_ret) begin
      n_fail++;
      $display("FAIL halt_hold bad_cycles=%0d want=0 ret=%0d want=%0d",
               bad, retired, m_ret);
    end
    @(negedge CLK);
    Reset = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b1;
    n_checks++;
    if (state !== 4'd0 || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL halt_reset st=%b ret=%0d want st=0 ret=0",
               state, retired);
    end
    m_ret = '0; m_ret2 = '0;
    run_instr(6'b000000, 6'b100000, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1'b0; OpCode = '0; func = '0;
    zero = 1'b0; sign = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_alu();
    test_branch();
    test_mem();
    test_jump();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mem();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
